fetch_ctrl: RTL and testbench

//  Sequencer for the instruction-fetch stage and IF/ID register. Merges EX-stage branch redirects,
//  ID-stage load-use stalls and an external halt/resume request into the fetch controls
//  (pc_src, dest_pc, pc_write_zero, IFID_pipeline_write_zero) plus an ID/EX flush.

---
 rtl/fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_perf_cnt.sv | 31 +++
 rtl/fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : fetch_ctrl_pkg
// Brief  : Shared fetch-control types and constants (also used by the hazard unit).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;
    localparam int         FLUSH_CNT_W   = 2;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |(lsb & PC_ALIGN_MASK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
//------------------------------------------------------------------------------
// Module : fetch_perf_cnt
// Brief  : Single saturating event counter, cleared by reset.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module : fetch_ctrl
// Brief  : Fetch-stage sequencer merging redirects, load-use stalls and halt.
//          Optional macro FETCH_PERF_CNT_EN adds stall/flush/halt counters.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            load_use_hazard,
    input  logic            halt_req,
    output logic            pc_src,
    output logic [PC_W-1:0] dest_pc,
    output logic            pc_write_zero,
    output logic            IFID_pipeline_write_zero,
    output logic            IDEX_flush,
    output logic            halted,
    output logic            misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [CNT_W-1:0] halt_cycles
`endif
);

    // Remaining FLUSH cycles after REDIR; REDIR itself is the first bubble.
    localparam logic [FLUSH_CNT_W-1:0] c_flush_init = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    fetch_state_t           r_state;
    logic [FLUSH_CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]        r_dest_pc;
    logic                   r_misalign;
    logic                   w_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_dest_pc  <= '0;
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_state   <= REDIR;
            r_dest_pc <= {redirect_pc[PC_W-1:2], 2'b00};
            if (is_misaligned(redirect_pc[1:0])) begin
                r_misalign <= 1'b1;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end
                end
                REDIR: begin
                    r_cnt <= c_flush_init;
                    if (FLUSH_CYCLES > 1) begin
                        r_state <= FLUSH;
                    end else begin
                        r_state <= halt_req ? HALT : RUN;
                    end
                end
                FLUSH: begin
                    r_cnt <= r_cnt - FLUSH_CNT_W'(1);
                    if (r_cnt <= FLUSH_CNT_W'(1)) begin
                        r_state <= halt_req ? HALT : RUN;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Stall yields to redirect and halt; gated by reset so outputs stay quiet while held.
    assign w_stall = (r_state == RUN) && load_use_hazard && !redirect_valid
                     && !halt_req && !reset;

    always_comb begin
        pc_src                   = 1'b0;
        pc_write_zero            = 1'b0;
        IFID_pipeline_write_zero = 1'b0;
        IDEX_flush               = 1'b0;
        halted                   = 1'b0;
        case (r_state)
            RUN: begin
                pc_write_zero = w_stall;
                IDEX_flush    = w_stall;
            end
            REDIR: begin
                pc_src                   = 1'b1;
                IFID_pipeline_write_zero = 1'b1;
                IDEX_flush               = 1'b1;
            end
            FLUSH: begin
                IFID_pipeline_write_zero = 1'b1;
            end
            HALT: begin
                pc_write_zero            = 1'b1;
                IFID_pipeline_write_zero = 1'b1;
                halted                   = 1'b1;
            end
            default: begin
                pc_src = 1'b0;
            end
        endcase
    end

    assign dest_pc      = r_dest_pc;
    assign misalign_err = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall),
        .count (stall_cycles)
    );

    fetch_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((r_state == REDIR) || (r_state == FLUSH)),
        .count (flush_cycles)
    );

    fetch_perf_cnt #(.W(CNT_W)) u_halt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (r_state == HALT),
        .count (halt_cycles)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_ctrl
// Brief  : Scoreboard bench for fetch_ctrl against a bubble/halt window model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

    localparam int PC_W         = 16;
    localparam int FLUSH_CYCLES = 2;

    logic            clk;
    logic            reset;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            load_use_hazard;
    logic            halt_req;
    logic            pc_src;
    logic [PC_W-1:0] dest_pc;
    logic            pc_write_zero;
    logic            IFID_pipeline_write_zero;
    logic            IDEX_flush;
    logic            halted;
    logic            misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]     stall_cycles;
    logic [15:0]     flush_cycles;
    logic [15:0]     halt_cycles;
`endif

    fetch_ctrl #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
`ifdef FETCH_PERF_CNT_EN
        ,
        .CNT_W        (16)
`endif
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .redirect_valid           (redirect_valid),
        .redirect_pc              (redirect_pc),
        .load_use_hazard          (load_use_hazard),
        .halt_req                 (halt_req),
        .pc_src                   (pc_src),
        .dest_pc                  (dest_pc),
        .pc_write_zero            (pc_write_zero),
        .IFID_pipeline_write_zero (IFID_pipeline_write_zero),
        .IDEX_flush               (IDEX_flush),
        .halted                   (halted),
        .misalign_err             (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles             (stall_cycles),
        .flush_cycles             (flush_cycles),
        .halt_cycles              (halt_cycles)
`endif
    );

    typedef struct packed {
        logic        pc_src;
        logic [15:0] dest_pc;
        logic        pcw;
        logic        ifid;
        logic        idex;
        logic        halted;
        logic        mis;
`ifdef FETCH_PERF_CNT_EN
        logic [15:0] sc;
        logic [15:0] fc;
        logic [15:0] hc;
`endif
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: a redirect opens a window of FLUSH_CYCLES bubble cycles,
    // the first of which steers the PC; halt mode is entered only outside that window.
    int          m_bubbles;
    bit          m_halt;
    logic [15:0] m_dest;
    bit          m_mis;
    int          m_sc, m_fc, m_hc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_bubbles = 0; m_halt = 0; m_dest = '0; m_mis = 0;
        m_sc = 0; m_fc = 0; m_hc = 0;
    endtask

    task automatic step(input logic r, input logic rv, input logic [15:0] pc,
                        input logic lu, input logic hr);
        obs_t e;
        bit   stall;
        @(negedge clk);
        reset = r; redirect_valid = rv; redirect_pc = pc;
        load_use_hazard = lu; halt_req = hr;
        e = '0;
        if (r) begin
            model_reset();
        end else begin
            stall    = (m_bubbles == 0) && !m_halt && lu && !rv && !hr;
            e.pc_src = (m_bubbles == FLUSH_CYCLES);
            e.dest_pc = m_dest;
            e.pcw    = m_halt || stall;
            e.ifid   = (m_bubbles > 0) || m_halt;
            e.idex   = (m_bubbles == FLUSH_CYCLES) || stall;
            e.halted = m_halt;
            e.mis    = m_mis;
`ifdef FETCH_PERF_CNT_EN
            e.sc = 16'(m_sc); e.fc = 16'(m_fc); e.hc = 16'(m_hc);
`endif
            m_sc += int'(stall);
            m_fc += int'(m_bubbles > 0);
            m_hc += int'(m_halt);
            if (rv) begin
                m_dest    = pc & 16'hFFFC;
                m_mis     = m_mis || (pc[1:0] != 2'b00);
                m_bubbles = FLUSH_CYCLES;
                m_halt    = 0;
            end else if (m_bubbles > 0) begin
                m_bubbles--;
                if (m_bubbles == 0) m_halt = hr;
            end else begin
                m_halt = hr;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Monitor: one observation per cycle, just ahead of the active edge.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '0;
                a.pc_src = pc_src; a.dest_pc = dest_pc; a.pcw = pc_write_zero;
                a.ifid = IFID_pipeline_write_zero; a.idex = IDEX_flush;
                a.halted = halted; a.mis = misalign_err;
`ifdef FETCH_PERF_CNT_EN
                a.sc = stall_cycles; a.fc = flush_cycles; a.hc = halt_cycles;
`endif
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL outputs cycle %0d: got %h required %h", cyc, a, e);
            end
        end
    end

    initial begin
        logic hr_lvl;
        int   wait_cnt;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        load_use_hazard = 1'b0; halt_req = 1'b0;
        model_reset();

        // Reset held with random inputs, then release idle.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        idle(2);
        // Aligned redirect.
        step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
        idle(4);
        // Two-cycle load-use stall.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(2);
        // Redirect with hazard in the same cycle; hazard ignored during bubbles.
        step(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(2);
        // Five-cycle halt, then resume.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(3);
        // Redirect mid-halt while halt stays requested.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0080, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(3);
        // Misaligned target: sticky error.
        step(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
        idle(5);
        // Reset in the middle of halt.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);

        // Randomised traffic with occasional resets.
        hr_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) hr_lvl = ~hr_lvl;
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 7) == 0),
                 16'($urandom),
                 1'($urandom_range(0, 3) == 0),
                 hr_lvl);
        end
        idle(1);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
